// File: rtl/mode_timer_pkg.sv
// Shared types for the mode_timer block: operating modes, FSM states and a
// width helper for parameter-derived vector sizes.
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_FREE_UP = 2'd2
    } tmr_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } tmr_state_t;

    // Number of bits needed to hold values 0..value (at least one bit).
    function automatic int unsigned tmr_bits(input int unsigned value);
        int unsigned bits;
        bits = 1;
        while ((value >> bits) != 0) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mode_timer_prescaler.sv
// Prescaler for mode_timer: divides the clock by presc+1 and reports the
// cycle in which the phase counter sits at its terminal value.
module tmr_prescaler #(
    parameter int p_presc_width = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_load,
    input  logic [p_presc_width-1:0] i_presc,
    input  logic                     i_clear,
    input  logic                     i_enable,
    output logic                     o_step
);

    localparam logic [p_presc_width-1:0] ONE = {{(p_presc_width-1){1'b0}}, 1'b1};

    logic [p_presc_width-1:0] p_cnt_q, p_cnt_d;
    logic [p_presc_width-1:0] presc_q, presc_d;

    // o_step is only acted on by the parent while it is counting.
    assign o_step = (p_cnt_q == presc_q);

    always_comb begin
        presc_d = i_load ? i_presc : presc_q;
        p_cnt_d = p_cnt_q;
        if (i_clear) begin
            p_cnt_d = '0;
        end else if (i_enable) begin
            p_cnt_d = o_step ? '0 : p_cnt_q + ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            p_cnt_q <= '0;
            presc_q <= '0;
        end else begin
            p_cnt_q <= p_cnt_d;
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/mode_timer.sv
// Programmable timer/counter: one-shot, auto-reload and free-running up-count
// with a prescaler, a one-cycle terminal pulse and a sticky event flag.
module mode_timer
    import tmr_pkg::*;
#(
    parameter int p_width       = 16,
    parameter int p_presc_width = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_load,
    input  logic [p_width-1:0]       i_reload,
    input  logic [p_presc_width-1:0] i_presc,
    input  logic [1:0]               i_mode,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_clear_flag,
    output logic [p_width-1:0]       o_count,
    output logic                     o_tick,
    output logic                     o_flag,
    output logic                     o_running
);

    localparam logic [p_width-1:0] ONE = {{(p_width-1){1'b0}}, 1'b1};

    tmr_state_t         state_q, state_d;
    logic [p_width-1:0] count_q, count_d;
    logic [p_width-1:0] reload_q, reload_d;
    logic [1:0]         mode_q, mode_d;
    logic               tick_q, tick_d;
    logic               flag_q, flag_d;
    logic               p_clear, p_enable, step;

    tmr_prescaler #(
        .p_presc_width(p_presc_width)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (i_load),
        .i_presc  (i_presc),
        .i_clear  (p_clear),
        .i_enable (p_enable),
        .o_step   (step)
    );

    // Control priority is load, then stop, then start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        p_clear  = 1'b0;
        p_enable = 1'b0;

        if (i_load) begin
            reload_d = i_reload;
            mode_d   = i_mode;
            count_d  = i_reload;
            state_d  = IDLE;
            p_clear  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!i_stop && i_start) begin
                        state_d = RUN;
                        p_clear = 1'b1;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state_d = IDLE;
                    end else begin
                        p_enable = 1'b1;
                        if (step) begin
                            case (mode_q)
                                MODE_RELOAD: begin
                                    if (count_q == '0) begin
                                        tick_d  = 1'b1;
                                        count_d = reload_q;
                                    end else begin
                                        count_d = count_q - ONE;
                                    end
                                end
                                MODE_FREE_UP: begin
                                    if (count_q == {p_width{1'b1}}) begin
                                        tick_d  = 1'b1;
                                        count_d = '0;
                                    end else begin
                                        count_d = count_q + ONE;
                                    end
                                end
                                // Reserved mode 3 falls in here as a one-shot.
                                default: begin
                                    if (count_q == '0) begin
                                        tick_d  = 1'b1;
                                        state_d = HALT;
                                    end else begin
                                        count_d = count_q - ONE;
                                    end
                                end
                            endcase
                        end
                    end
                end
                HALT: begin
                    if (!i_stop && i_start) begin
                        count_d = reload_q;
                        state_d = RUN;
                        p_clear = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        flag_d = tick_d | (flag_q & ~i_clear_flag);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tick_q   <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            flag_q   <= flag_d;
        end
    end

    assign o_count   = count_q;
    assign o_tick    = tick_q;
    assign o_flag    = flag_q;
    assign o_running = (state_q == RUN);

endmodule

// File: tb/tb_mode_timer.sv
// Self-checking bench for mode_timer (W=4, P=4): directed scenarios plus a
// randomized run compared against a cycle-level reference model.
module tb_mode_timer;

    logic       i_clk;
    logic       i_reset;
    logic       i_load;
    logic [3:0] i_reload;
    logic [3:0] i_presc;
    logic [1:0] i_mode;
    logic       i_start;
    logic       i_stop;
    logic       i_clear_flag;
    logic [3:0] o_count;
    logic       o_tick;
    logic       o_flag;
    logic       o_running;

    int tests_run;
    int tests_failed;

    // Reference model state, kept as plain integers and flags.
    int m_count, m_reload, m_presc, m_mode, m_phase;
    bit m_run, m_halt, m_tick, m_flag;

    mode_timer #(
        .p_width(4),
        .p_presc_width(4)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (i_load),
        .i_reload     (i_reload),
        .i_presc      (i_presc),
        .i_mode       (i_mode),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_clear_flag (i_clear_flag),
        .o_count      (o_count),
        .o_tick       (o_tick),
        .o_flag       (o_flag),
        .o_running    (o_running)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_presc = 0; m_mode = 0; m_phase = 0;
        m_run = 0; m_halt = 0; m_tick = 0; m_flag = 0;
    endtask

    // Applies one clock edge of the timer's rules to the model.
    task automatic model_update();
        bit t;
        t = 0;
        if (!i_reset) begin
            model_reset();
            return;
        end
        if (i_load) begin
            m_reload = int'(i_reload);
            m_presc  = int'(i_presc);
            m_mode   = int'(i_mode);
            m_count  = int'(i_reload);
            m_phase  = 0;
            m_run    = 0;
            m_halt   = 0;
        end else if (m_run) begin
            if (i_stop) begin
                m_run = 0;
            end else if (m_phase == m_presc) begin
                m_phase = 0;
                if (m_mode == 1) begin
                    if (m_count == 0) begin
                        t = 1;
                        m_count = m_reload;
                    end else begin
                        m_count = m_count - 1;
                    end
                end else if (m_mode == 2) begin
                    m_count = (m_count + 1) % 16;
                    if (m_count == 0) t = 1;
                end else begin
                    if (m_count == 0) begin
                        t = 1;
                        m_run = 0;
                        m_halt = 1;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end else if (!i_stop && i_start) begin
            if (m_halt) m_count = m_reload;
            m_halt  = 0;
            m_run   = 1;
            m_phase = 0;
        end
        m_tick = t;
        m_flag = t | (m_flag & !i_clear_flag);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick_clk();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic load_cfg(input int reload, input int presc, input int mode);
        i_reload = 4'(reload);
        i_presc  = 4'(presc);
        i_mode   = 2'(mode);
        i_load   = 1'b1;
        tick_clk();
        i_load   = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick_clk();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (o_count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", o_count);
        end
        tests_run++;
        if ({o_tick, o_flag, o_running} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got tick/flag/run=%b expected 000", {o_tick, o_flag, o_running});
        end
        tick_clk();
        i_reset = 1'b1;
        tick_clk();
    endtask

    task automatic test_reload_seq();
        int exp_seq[8] = '{3, 3, 2, 2, 1, 1, 0, 0};
        load_cfg(3, 1, 1);
        pulse_start();
        tests_run++;
        if (o_running !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reload_running: got %b expected 1", o_running);
        end
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick_clk();
            tests_run++;
            if (o_count !== 4'(exp_seq[k % 8]) || o_tick !== ((k == 8) || (k == 16))) begin
                tests_failed++;
                $display("[TB] FAIL reload_seq[%0d]: got count=%0d tick=%b expected count=%0d tick=%b",
                         k, o_count, o_tick, exp_seq[k % 8], (k == 8) || (k == 16));
            end
        end
    endtask

    task automatic test_reset_running();
        i_reset = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({o_count, o_tick, o_flag, o_running} !== 7'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got count=%0d tick=%b flag=%b run=%b expected all 0",
                     o_count, o_tick, o_flag, o_running);
        end
        tick_clk();
        i_reset = 1'b1;
        for (int k = 0; k < 6; k++) tick_clk();
        tests_run++;
        if (o_count !== 4'd0 || o_running !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_resume: got count=%0d run=%b expected 0/0", o_count, o_running);
        end
    endtask

    task automatic test_oneshot();
        int ticks;
        ticks = 0;
        load_cfg(2, 0, 0);
        pulse_start();
        for (int k = 1; k <= 6; k++) begin
            tick_clk();
            if (o_tick) ticks++;
            if (k == 3) begin
                tests_run++;
                if (o_tick !== 1'b1 || o_count !== 4'd0 || o_running !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL oneshot_expire: got tick=%b count=%0d run=%b expected 1/0/0",
                             o_tick, o_count, o_running);
                end
            end
        end
        tests_run++;
        if (ticks != 1 || o_count !== 4'd0 || o_running !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL oneshot_halt: got ticks=%0d count=%0d run=%b expected 1/0/0",
                     ticks, o_count, o_running);
        end
        pulse_start();
        tests_run++;
        if (o_count !== 4'd2 || o_running !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL oneshot_restart: got count=%0d run=%b expected 2/1", o_count, o_running);
        end
        for (int k = 0; k < 4; k++) tick_clk();
    endtask

    task automatic test_free_up();
        i_clear_flag = 1'b1;
        tick_clk();
        i_clear_flag = 1'b0;
        tests_run++;
        if (o_flag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flag_clear: got %b expected 0", o_flag);
        end
        load_cfg(14, 0, 2);
        pulse_start();
        for (int k = 1; k <= 18; k++) begin
            i_clear_flag = (k == 10) || (k == 18);
            tick_clk();
            i_clear_flag = 1'b0;
            tests_run++;
            if (o_count !== 4'((14 + k) % 16) || o_tick !== ((k == 2) || (k == 18)) ||
                o_flag !== ((k >= 2 && k < 10) || k == 18)) begin
                tests_failed++;
                $display("[TB] FAIL free_up[%0d]: got count=%0d tick=%b flag=%b expected count=%0d tick=%b flag=%b",
                         k, o_count, o_tick, o_flag, (14 + k) % 16, (k == 2) || (k == 18),
                         (k >= 2 && k < 10) || k == 18);
            end
        end
    endtask

    task automatic test_stop_resume();
        load_cfg(9, 3, 1);
        pulse_start();
        for (int k = 1; k <= 18; k++) begin
            i_stop = (k == 18);
            tick_clk();
        end
        i_stop = 1'b0;
        for (int k = 0; k < 5; k++) tick_clk();
        tests_run++;
        if (o_count !== 4'd5 || o_running !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stop_hold: got count=%0d run=%b expected 5/0", o_count, o_running);
        end
        pulse_start();
        for (int k = 1; k <= 4; k++) begin
            tick_clk();
            if (k >= 3) begin
                tests_run++;
                if (o_count !== ((k == 4) ? 4'd4 : 4'd5)) begin
                    tests_failed++;
                    $display("[TB] FAIL resume_phase[%0d]: got %0d expected %0d", k, o_count, (k == 4) ? 4 : 5);
                end
            end
        end
    endtask

    task automatic test_priority();
        i_reload = 4'd7;
        i_load   = 1'b1;
        i_stop   = 1'b1;
        i_start  = 1'b1;
        tick_clk();
        i_load = 1'b0; i_stop = 1'b0; i_start = 1'b0;
        tests_run++;
        if (o_count !== 4'd7 || o_running !== 1'b0 || o_tick !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_priority: got count=%0d run=%b tick=%b expected 7/0/0",
                     o_count, o_running, o_tick);
        end
        for (int k = 0; k < 3; k++) tick_clk();
        tests_run++;
        if (o_count !== 4'd7) begin
            tests_failed++;
            $display("[TB] FAIL idle_hold: got %0d expected 7", o_count);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            i_load       = ($urandom_range(99, 0) < 3);
            i_start      = ($urandom_range(99, 0) < 10);
            i_stop       = ($urandom_range(99, 0) < 4);
            i_clear_flag = ($urandom_range(99, 0) < 5);
            i_reload     = 4'($urandom_range(15, 0));
            i_presc      = 4'($urandom_range(3, 0));
            i_mode       = 2'($urandom_range(3, 0));
            tick_clk();
            tests_run++;
            if (o_count !== 4'(m_count) || o_tick !== m_tick || o_flag !== m_flag || o_running !== m_run) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d]: got count=%0d tick=%b flag=%b run=%b expected count=%0d tick=%b flag=%b run=%b",
                         k, o_count, o_tick, o_flag, o_running, m_count, m_tick, m_flag, m_run);
            end
        end
        i_load = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_clear_flag = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_reset      = 1'b1;
        i_load       = 1'b0;
        i_reload     = 4'd0;
        i_presc      = 4'd0;
        i_mode       = 2'd0;
        i_start      = 1'b0;
        i_stop       = 1'b0;
        i_clear_flag = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_reload_seq();
        test_reset_running();
        test_oneshot();
        test_free_up();
        test_stop_resume();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mode_timer.md
# mode_timer

Programmable multi-mode timer/counter with a built-in prescaler. It provides one-shot countdown, auto-reload periodic countdown and free-running up-count. It emits a one-cycle terminal pulse and a sticky event flag. It is the next-generation timing primitive for the timer design: it replaces ad-hoc chains of fixed-range counters, and the control FSM and display logic instantiate it wherever a programmable period or timeout is needed.

## Interface
- p_width, 16: counter width W, in bits.
- p_presc_width, 8: prescaler width P, in bits. The division ratio is presc+1.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_load  in  1  latch i_reload, i_presc and i_mode; load the count.
- i_reload  in  W  reload/start value.
- i_presc  in  P  prescaler terminal value.
- i_mode  in  2  operating mode, a tmr_mode_t value.
- i_start  in  1  start or resume counting.
- i_stop  in  1  pause counting; the count is held.
- i_clear_flag  in  1  clear o_flag.
- o_count  out  W  current count.
- o_tick  out  1  one-cycle pulse on a terminal event.
- o_flag  out  1  sticky event flag.
- o_running  out  1  high while in RUN.

## Operation
- **Reset values:** o_count=0, o_tick=0, o_flag=0, o_running=0. Internal registers: reload_reg=0, presc_reg=0, mode_reg=MODE_ONESHOT, p_cnt=0, state=IDLE.
- **States:**
  - IDLE: stopped; the count is valid and resumable.
  - RUN: counting.
  - HALT: a one-shot has expired; o_count is held at 0.
- **Control priority, per cycle:** i_load > i_stop > i_start.
- **i_load (any state):**
  - reload_reg←i_reload, presc_reg←i_presc, mode_reg←i_mode.
  - o_count←i_reload, p_cnt←0, state←IDLE, o_tick←0.
- **i_stop in RUN:** state←IDLE; o_count and p_cnt are held. i_stop in other states is ignored.
- **i_start:**
  - In IDLE: state←RUN, p_cnt←0, counting continues from the current o_count.
  - In HALT: o_count←reload_reg, p_cnt←0, state←RUN.
  - In RUN: ignored.
- **Prescaler (RUN only):**
  - If p_cnt==presc_reg: step=1 and p_cnt←0.
  - Otherwise p_cnt←p_cnt+1.
- **Behaviour on step:**
  - MODE_ONESHOT: if o_count==0, then o_tick←1 and state←HALT, with the count held at 0. Otherwise o_count←o_count−1.
  - MODE_RELOAD: if o_count==0, then o_tick←1 and o_count←reload_reg. Otherwise decrement.
  - MODE_FREE_UP: if o_count==2^W−1, then o_tick←1 and o_count←0. Otherwise increment.
  - Mode value 3 is reserved and behaves as MODE_ONESHOT.
- **o_tick** is 0 in every cycle that does not produce a terminal event.
- **o_flag:**
  - Set by any terminal event.
  - Cleared by i_clear_flag.
  - If both happen in the same cycle, set wins.
  - i_load does not affect o_flag.
- **Arithmetic:** unsigned and modulo 2^W; there are no out-of-range states.
- **Reset mid-operation:** all registers return asynchronously to their reset values. Counting resumes only after a new i_start.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Start sampled at edge n: o_running=1 after edge n. The first step is in the cycle where p_cnt==presc_reg, so the count first changes at edge n+presc+1.
- **Step period:** presc+1 cycles.
- **Terminal period:** (reload+1)·(presc+1) cycles in RELOAD mode and in ONESHOT mode started from reload. In FREE_UP mode from 0 it is 2^W·(presc+1) cycles.
- o_tick is asserted in the same cycle that the wrapped/reloaded count becomes visible on o_count.
- i_stop followed by i_start: the prescaler phase restarts from 0, so a partial prescale period is discarded.

## Structure
- Package tmr_pkg holds:
  - typedef enum logic [1:0] tmr_mode_t: MODE_ONESHOT=0, MODE_RELOAD=1, MODE_FREE_UP=2.
  - typedef enum tmr_state_t: IDLE, RUN, HALT.
  - Width helper function for parameter-derived widths (shared with the existing def helpers).
- One sub-module: tmr_prescaler. It holds p_cnt/presc_reg and takes clear/enable inputs; its output is step.
- The top level contains the FSM, the count datapath and the flag logic.

## Test plan
- Reset while running, mode RELOAD: all outputs and state go to their reset values; the count does not resume until i_start.
- Load reload=3, presc=1, mode RELOAD, start: o_tick pulses every 8 cycles; o_count sequence is 3,3,2,2,1,1,0,0,3…
- Load reload=2, presc=0, mode ONESHOT, start: after 3 steps one o_tick; state HALT with o_count=0 held and o_running=0. A second i_start reloads 2 and runs again.
- FREE_UP with W=4, presc=0, loaded to 14: counts 15 then 0 with o_tick at the 0; o_flag sets and stays set; i_clear_flag coinciding with the next tick leaves o_flag=1.
- Mode RELOAD, presc=3, reload=9, stop at count=5: o_count held at 5. Restart: count 4 appears exactly 4 cycles after the start edge.
- i_load, i_stop and i_start all asserted together in RUN: load wins, state=IDLE, o_count=i_reload, o_running=0.
